fsm_result_sink: RTL and testbench
==================================

# fsm_result_sink

Downstream consumer of the `fsm_core` result stream. Captures each `data_out` word and its `specreg` tag when `intr` is raised, returns `ack` to `fsm_core` under a four-phase handshake, and buffers results in a small first-word-fall-through FIFO for a downstream reader. Latches `stop` as an end-of-stream condition and counts cycles where the producer was stalled by a full buffer.

## Interface
Parameters:
- `DW`, 23, data word width; must match `fsm_core` `data_out`.
- `DEPTH`, 4, FIFO depth in entries; power of 2, minimum 2.
- `AW`, log2(`DEPTH`), pointer width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `arst_n`  in  1  asynchronous active-low reset; all state cleared immediately on assertion.
- `intr`  in  1  result request from `fsm_core`, held high until `ack` is seen.
- `data_out`  in  DW  result word from `fsm_core`, valid while `intr` is high.
- `specreg`  in  1  tag bit accompanying `data_out`.
- `stop`  in  1  end-of-stream indication from `fsm_core`.
- `ack`  out  1  registered one-cycle acknowledge to `fsm_core`.
- `rd_en`  in  1  pop request from the downstream reader.
- `rd_valid`  out  1  FIFO head valid (not empty).
- `rd_data`  out  DW  FIFO head data word.
- `rd_spec`  out  1  FIFO head tag bit.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `level`  out  AW+1  current entry count, 0..`DEPTH`.
- `done`  out  1  sticky flag; `stop` has been seen.
- `stall_cnt`  out  16  saturating count of stalled request cycles.

## Operation
- Handshake FSM with three states:
  - `IDLE`: if `intr`=1, `full`=0 and `done`=0 at the edge, write {`specreg`,`data_out`} into the FIFO and go to `ACK`. Otherwise stay.
  - `ACK`: `ack`=1 for exactly this one cycle. Go to `WAIT_LOW` unconditionally.
  - `WAIT_LOW`: `ack`=0. Stay while `intr`=1. Return to `IDLE` when `intr`=0 is sampled.
- Each request is captured exactly once. A new capture requires `intr` to fall and then rise again.
- FIFO storage:
  - Entries are DW+1 bits wide.
  - Write and read pointers are AW bits and wrap modulo `DEPTH`.
  - `level` is tracked separately with AW+1 bits.
- Reads are first-word-fall-through. `rd_data`/`rd_spec` show the head entry whenever `rd_valid`=1. `rd_en`=1 with `rd_valid`=1 pops at the edge.
- Boundary conditions:
  - `rd_en` while empty: ignored, no pointer or level change.
  - Capture while `full`=1: blocked, even if `rd_en` pops in the same cycle. The capture retries on the next cycle.
  - Simultaneous capture and pop when not full and not empty: `level` is unchanged and both pointers advance.
  - Simultaneous capture and pop when empty: the write happens and `level` becomes 1. Pop is ignored because `rd_valid` was 0.
- `stop`:
  - Sampled high in any state, it sets `done`, which stays set until reset.
  - If `stop` and a valid capture condition occur together in `IDLE`, the word is still captured as the final entry.
  - After `done`=1, no further captures occur; the FSM stays in `IDLE` and `ack` is never raised again. Reads continue normally.
- `stall_cnt` increments each cycle in which the FSM is in `IDLE`, `intr`=1, `full`=1 and `done`=0. It saturates at 0xFFFF.

## Timing
- Reset values: `ack`=0, `rd_valid`=0, `rd_data`=0, `rd_spec`=0, `full`=0, `level`=0, `done`=0, `stall_cnt`=0, FSM=`IDLE`, pointers=0. FIFO storage is not required to clear.
- Capture to `ack`: `intr` sampled at edge N, so `ack` is high from edge N to edge N+1.
- Capture to read: `rd_valid` and head data are visible from edge N onward (1-cycle latency into an empty FIFO).
- Minimum request cycle: 3 clocks (`IDLE`→`ACK`→`WAIT_LOW`→`IDLE`), given `intr` drops during `ACK`.
- `full`, `level` and `rd_valid` are registered or derived from registered state only; they have no combinational path from `intr` or `rd_en`.
- Reset mid-operation: `arst_n`=0 during `ACK` drops `ack` immediately, empties the FIFO and clears `done`. After release, a still-high `intr` is captured as a new request.

## Test plan
- Reset, then one request (`intr`=1, `data_out`=23'h00FFFF, `specreg`=1, dropped after `ack`): `ack` is high for exactly 1 cycle. Head shows `rd_valid`=1, `rd_data`=23'h00FFFF, `rd_spec`=1, and `level`=1. After one `rd_en` pop, `level`=0.
- `intr` held high for 10 cycles: exactly one capture, one `ack` pulse, and `level`=1.
- Five back-to-back requests (values 1..5) with no reads: `full`=1 after the 4th. The 5th stalls and `stall_cnt` counts the stalled cycles. Popping one entry lets value 5 be captured. Reads then return 2,3,4,5 in order.
- `stop`=1 together with a request carrying 23'h7FFFFF: that word is captured, `done`=1, and a later request gets no `ack`. The captured word is still readable.
- `rd_en` held high while the FIFO is empty: `level` stays 0 and no underflow occurs. A capture and pop in the same cycle at `level`=2 leaves `level`=2.
- `arst_n` pulsed low during `ACK` with `level`=3: all outputs return to reset values immediately.

Source files
------------

// File: rtl/fsm_result_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_result_sink
//  Description : Result consumer for fsm_core. Captures {specreg, data_out}
//                when intr is raised, answers with a one-cycle registered ack
//                (four-phase handshake), and queues results in a small
//                first-word-fall-through FIFO for a downstream reader.
//                Latches stop as a sticky end-of-stream flag and counts the
//                cycles in which a pending request was held off by a full FIFO.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    arst_n     in   1      asynchronous active-low reset
//    intr       in   1      result request, held until ack is seen
//    data_out   in   DW     result word, valid while intr is high
//    specreg    in   1      tag bit accompanying data_out
//    stop       in   1      end-of-stream indication
//    ack        out  1      registered one-cycle acknowledge
//    rd_en      in   1      pop request from the reader
//    rd_valid   out  1      FIFO head valid (not empty)
//    rd_data    out  DW     FIFO head data word (0 when empty)
//    rd_spec    out  1      FIFO head tag bit (0 when empty)
//    full       out  1      FIFO holds DEPTH entries
//    level      out  AW+1   current entry count
//    done       out  1      sticky: stop has been seen
//    stall_cnt  out  16     saturating count of full-stalled request cycles
// ============================================================================
module fsm_result_sink #(
   parameter int DW    = 23,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          intr,
   input  logic [DW-1:0] data_out,
   input  logic          specreg,
   input  logic          stop,
   output logic          ack,
   input  logic          rd_en,
   output logic          rd_valid,
   output logic [DW-1:0] rd_data,
   output logic          rd_spec,
   output logic          full,
   output logic [AW:0]   level,
   output logic          done,
   output logic [15:0]   stall_cnt
);

   localparam logic [1:0]  c_IDLE     = 2'd0;
   localparam logic [1:0]  c_ACK      = 2'd1;
   localparam logic [1:0]  c_WAIT_LOW = 2'd2;
   localparam logic [AW:0] c_DEPTH    = DEPTH[AW:0];

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic          r_ack;
   logic          r_done;
   logic [15:0]   r_stall_cnt;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [DW:0]   r_mem [DEPTH];

   logic          w_full;
   logic          w_empty;
   logic          w_capture;
   logic          w_pop;
   logic          w_stall;
   logic [DW:0]   w_head;

   // Status comes purely from the registered level so there is no
   // combinational path from intr or rd_en to full/level/rd_valid.
   assign w_full  = (r_level == c_DEPTH);
   assign w_empty = (r_level == '0);

   // The done term uses the registered flag: a stop arriving together with a
   // valid request still lets that word in as the final entry.
   assign w_capture = (r_state == c_IDLE) && intr && !w_full && !r_done;
   assign w_pop     = rd_en && !w_empty;
   assign w_stall   = (r_state == c_IDLE) && intr && w_full && !r_done;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:     if (w_capture) w_state_nxt = c_ACK;
         c_ACK:      w_state_nxt = c_WAIT_LOW;
         c_WAIT_LOW: if (!intr) w_state_nxt = c_IDLE;
         default:    w_state_nxt = c_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= c_IDLE;
         r_ack       <= 1'b0;
         r_done      <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= w_capture;
         if (stop) begin
            r_done <= 1'b1;
         end
         if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_capture) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         // Simultaneous push and pop leave the count unchanged.
         if (w_capture && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (w_pop && !w_capture) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   // Storage carries no reset; the output gating below hides stale contents.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_mem[r_wr_ptr] <= {specreg, data_out};
      end
   end

   assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

   // ---------------------------------------------------------------- Outputs
   assign ack       = r_ack;
   assign rd_valid  = !w_empty;
   assign rd_data   = w_head[DW-1:0];
   assign rd_spec   = w_head[DW];
   assign full      = w_full;
   assign level     = r_level;
   assign done      = r_done;
   assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fsm_result_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsm_result_sink
//  Description : Directed self-checking bench for fsm_result_sink.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_result_sink;

   localparam int DW    = 23;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk;
   logic          arst_n;
   logic          intr;
   logic [DW-1:0] data_out;
   logic          specreg;
   logic          stop;
   logic          ack;
   logic          rd_en;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          rd_spec;
   logic          full;
   logic [AW:0]   level;
   logic          done;
   logic [15:0]   stall_cnt;

   int n_checks;
   int n_errors;
   int ack_seen;

   fsm_result_sink #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .intr      (intr),
      .data_out  (data_out),
      .specreg   (specreg),
      .stop      (stop),
      .ack       (ack),
      .rd_en     (rd_en),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_spec   (rd_spec),
      .full      (full),
      .level     (level),
      .done      (done),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the negedge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Full handshake for one word: raise intr, wait (bounded) for ack, drop intr
   // and return the FSM to IDLE.
   task automatic request(input logic [DW-1:0] val, input logic tag);
      int waited;
      intr     = 1'b1;
      data_out = val;
      specreg  = tag;
      waited   = 0;
      do begin
         step();
         waited++;
      end while (!ack && waited < 20);
      check("req_ack", {31'd0, ack}, 32'd1);
      intr = 1'b0;
      step();
      step();
   endtask

   task automatic pop();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      arst_n   = 1'b0;
      intr     = 1'b0;
      data_out = '0;
      specreg  = 1'b0;
      stop     = 1'b0;
      rd_en    = 1'b0;

      // ---- reset values
      #12;
      check("rst_ack",   {31'd0, ack},      32'd0);
      check("rst_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_data",  {9'd0, rd_data},   32'd0);
      check("rst_spec",  {31'd0, rd_spec},  32'd0);
      check("rst_full",  {31'd0, full},     32'd0);
      check("rst_level", {29'd0, level},    32'd0);
      check("rst_done",  {31'd0, done},     32'd0);
      check("rst_stall", {16'd0, stall_cnt},32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      step();

      // ---- single request
      intr     = 1'b1;
      data_out = 23'h00FFFF;
      specreg  = 1'b1;
      step();
      check("t1_ack_hi",  {31'd0, ack},      32'd1);
      check("t1_valid",   {31'd0, rd_valid}, 32'd1);
      check("t1_data",    {9'd0, rd_data},   32'h00FFFF);
      check("t1_spec",    {31'd0, rd_spec},  32'd1);
      check("t1_level",   {29'd0, level},    32'd1);
      intr = 1'b0;
      step();
      check("t1_ack_lo",  {31'd0, ack},      32'd0);
      step();
      pop();
      check("t1_pop_lvl", {29'd0, level},    32'd0);

      // ---- intr held for 10 cycles: one capture only
      intr     = 1'b1;
      data_out = 23'h000123;
      specreg  = 1'b0;
      ack_seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ack) ack_seen++;
      end
      check("t2_acks",  ack_seen,               32'd1);
      check("t2_level", {29'd0, level},         32'd1);
      check("t2_data",  {9'd0, rd_data},        32'h000123);
      intr = 1'b0;
      step();
      pop();
      check("t2_empty", {29'd0, level},         32'd0);

      // ---- five requests, no reads: fill, stall, then drain
      for (int v = 1; v <= 4; v++) request(v[DW-1:0], 1'b0);
      check("t3_full",  {31'd0, full},          32'd1);
      check("t3_lvl4",  {29'd0, level},         32'd4);
      intr     = 1'b1;
      data_out = 23'd5;
      ack_seen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ack) ack_seen++;
      end
      check("t3_noack",   ack_seen,              32'd0);
      check("t3_stall3",  {16'd0, stall_cnt},    32'd3);
      rd_en = 1'b1;               // pop while full: capture still blocked
      step();
      rd_en = 1'b0;
      check("t3_stall4",  {16'd0, stall_cnt},    32'd4);
      check("t3_lvl3",    {29'd0, level},        32'd3);
      check("t3_ack_blk", {31'd0, ack},          32'd0);
      step();                     // retry succeeds now
      check("t3_ack5",    {31'd0, ack},          32'd1);
      check("t3_lvl4b",   {29'd0, level},        32'd4);
      intr = 1'b0;
      step();
      step();
      for (int v = 2; v <= 5; v++) begin
         check("t3_order", {9'd0, rd_data}, v);
         pop();
      end
      check("t3_drained", {29'd0, level},        32'd0);

      // ---- stop with a request
      stop     = 1'b1;
      intr     = 1'b1;
      data_out = 23'h7FFFFF;
      specreg  = 1'b0;
      step();
      check("t4_ack",   {31'd0, ack},            32'd1);
      check("t4_done",  {31'd0, done},           32'd1);
      check("t4_level", {29'd0, level},          32'd1);
      stop = 1'b0;
      intr = 1'b0;
      step();
      step();
      intr     = 1'b1;
      data_out = 23'h000055;
      ack_seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ack) ack_seen++;
      end
      check("t4_noack", ack_seen,                32'd0);
      check("t4_lvl",   {29'd0, level},          32'd1);
      check("t4_stall", {16'd0, stall_cnt},      32'd4);
      check("t4_data",  {9'd0, rd_data},         32'h7FFFFF);
      check("t4_sticky",{31'd0, done},           32'd1);
      intr = 1'b0;
      pop();
      check("t4_empty", {29'd0, level},          32'd0);

      // ---- reset to clear done
      arst_n = 1'b0;
      #1;
      check("r2_done",  {31'd0, done},           32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      step();

      // ---- rd_en while empty, then push+pop at level 2
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) step();
      rd_en = 1'b0;
      check("t5_lvl0",  {29'd0, level},          32'd0);
      check("t5_valid", {31'd0, rd_valid},       32'd0);
      request(23'h00000A, 1'b0);
      request(23'h00000B, 1'b1);
      check("t5_lvl2",  {29'd0, level},          32'd2);
      intr     = 1'b1;
      data_out = 23'h00000C;
      specreg  = 1'b0;
      rd_en    = 1'b1;
      step();
      rd_en = 1'b0;
      check("t5_ack",   {31'd0, ack},            32'd1);
      check("t5_same",  {29'd0, level},          32'd2);
      check("t5_head",  {9'd0, rd_data},         32'h00000B);
      check("t5_hspec", {31'd0, rd_spec},        32'd1);
      intr = 1'b0;
      step();
      step();

      // ---- reset during ACK at level 3
      intr     = 1'b1;
      data_out = 23'h00000D;
      step();
      check("t6_ack",   {31'd0, ack},            32'd1);
      check("t6_lvl3",  {29'd0, level},          32'd3);
      #2;
      arst_n = 1'b0;
      #1;
      check("t6_r_ack",   {31'd0, ack},          32'd0);
      check("t6_r_level", {29'd0, level},        32'd0);
      check("t6_r_valid", {31'd0, rd_valid},     32'd0);
      check("t6_r_data",  {9'd0, rd_data},       32'd0);
      check("t6_r_full",  {31'd0, full},         32'd0);
      check("t6_r_done",  {31'd0, done},         32'd0);
      @(negedge clk);
      arst_n = 1'b1;
      step();                     // intr still high: new capture
      check("t6_recap",   {31'd0, ack},          32'd1);
      check("t6_lvl1",    {29'd0, level},        32'd1);
      check("t6_data",    {9'd0, rd_data},       32'h00000D);
      intr = 1'b0;
      step();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
